// File: rtl/remote_cmd_seq_if.sv
// Link bundle for remote_cmd_seq: command FIFO push port, transmitter handshake
// and status. slave is the sequencer's view, master is the host/bench view.
interface remote_cmd_seq_if #(
    parameter int CMD_W  = 16,
    parameter int RESP_W = 8,
    parameter int TMO_W  = 24
);
    logic              push;
    logic [CMD_W-1:0]  push_cmd;
    logic [7:0]        push_nresp;
    logic              full;
    logic              empty;
    logic [TMO_W-1:0]  tmo_val;
    logic              abort;
    logic [CMD_W-1:0]  cmd;
    logic              send_cmd;
    logic              cmd_sent;
    logic              resp_rdy;
    logic [RESP_W-1:0] resp;
    logic              busy;
    logic              cmd_done;
    logic [7:0]        resp_cnt;
    logic              err_resp;
    logic              err_tmo;
    logic [RESP_W-1:0] bad_resp;

    modport slave (
        input  push, push_cmd, push_nresp, tmo_val, abort, cmd_sent, resp_rdy, resp,
        output full, empty, cmd, send_cmd, busy, cmd_done, resp_cnt,
               err_resp, err_tmo, bad_resp
    );

    modport master (
        output push, push_cmd, push_nresp, tmo_val, abort, cmd_sent, resp_rdy, resp,
        input  full, empty, cmd, send_cmd, busy, cmd_done, resp_cnt,
               err_resp, err_tmo, bad_resp
    );
endinterface

// File: rtl/remote_cmd_seq.sv
// Host-side command sequencer: buffers {cmd, nresp} entries, issues them one at a
// time to a UART transmitter, counts and checks responses, flags timeouts.
module remote_cmd_seq #(
    parameter int                CMD_W    = 16,
    parameter int                RESP_W   = 8,
    parameter int                DEPTH    = 8,
    parameter int                TMO_W    = 24,
    parameter logic [RESP_W-1:0] EXP_RESP = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    remote_cmd_seq_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_SENT, WAIT_RESP, ERR} state_t;

    state_t             state;
    logic [CMD_W+7:0]   mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [CMD_W-1:0]   head_cmd;
    logic [7:0]         head_nresp;
    logic [7:0]         nresp;
    logic [TMO_W-1:0]   timer;
    logic [TMO_W-1:0]   timer_inc;
    logic               pop;
    logic               wr_en;
    logic               tmo_hit;

    logic [CMD_W-1:0]   cmd_r;
    logic               send_cmd_r;
    logic               busy_r;
    logic               cmd_done_r;
    logic [7:0]         resp_cnt_r;
    logic               err_resp_r;
    logic               err_tmo_r;
    logic [RESP_W-1:0]  bad_resp_r;

    assign bus.empty    = (wr_ptr == rd_ptr);
    assign bus.full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign bus.cmd      = cmd_r;
    assign bus.send_cmd = send_cmd_r;
    assign bus.busy     = busy_r;
    assign bus.cmd_done = cmd_done_r;
    assign bus.resp_cnt = resp_cnt_r;
    assign bus.err_resp = err_resp_r;
    assign bus.err_tmo  = err_tmo_r;
    assign bus.bad_resp = bad_resp_r;

    assign {head_cmd, head_nresp} = mem[rd_ptr[AW-1:0]];

    // A pop frees the slot being written, so a full FIFO still accepts a push that cycle.
    assign pop   = (state == IDLE) && !bus.empty && !err_resp_r && !err_tmo_r && !bus.abort;
    assign wr_en = bus.push && !bus.abort && (!bus.full || pop);

    assign timer_inc = (&timer) ? timer : timer + {{(TMO_W-1){1'b0}}, 1'b1};
    assign tmo_hit   = (bus.tmo_val != '0) &&
                       (({1'b0, timer} + {{TMO_W{1'b0}}, 1'b1}) == {1'b0, bus.tmo_val});

    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)   rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {bus.push_cmd, bus.push_nresp};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd_r      <= '0;
            nresp      <= '0;
            timer      <= '0;
            send_cmd_r <= 1'b0;
            busy_r     <= 1'b0;
            cmd_done_r <= 1'b0;
            resp_cnt_r <= '0;
            err_resp_r <= 1'b0;
            err_tmo_r  <= 1'b0;
            bad_resp_r <= '0;
        end else if (bus.abort) begin
            state      <= IDLE;
            timer      <= '0;
            send_cmd_r <= 1'b0;
            busy_r     <= 1'b0;
            cmd_done_r <= 1'b0;
            err_resp_r <= 1'b0;
            err_tmo_r  <= 1'b0;
            bad_resp_r <= '0;
        end else begin
            send_cmd_r <= 1'b0;
            cmd_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cmd_r      <= head_cmd;
                        nresp      <= head_nresp;
                        resp_cnt_r <= '0;
                        timer      <= '0;
                        send_cmd_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    timer <= '0;
                    state <= WAIT_SENT;
                end
                WAIT_SENT: begin
                    if (bus.cmd_sent) begin
                        timer <= '0;
                        if (nresp == 8'd0) begin
                            cmd_done_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            state <= WAIT_RESP;
                        end
                    end else if (tmo_hit) begin
                        err_tmo_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state     <= ERR;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                // A response arriving in the expiry cycle counts as activity and wins.
                WAIT_RESP: begin
                    if (bus.resp_rdy) begin
                        resp_cnt_r <= resp_cnt_r + 8'd1;
                        timer      <= '0;
                        if (bus.resp != EXP_RESP) begin
                            err_resp_r <= 1'b1;
                            if (!err_resp_r) bad_resp_r <= bus.resp;
                            busy_r     <= 1'b0;
                            state      <= ERR;
                        end else if (resp_cnt_r + 8'd1 == nresp) begin
                            cmd_done_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state      <= IDLE;
                        end
                    end else if (tmo_hit) begin
                        err_tmo_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state     <= ERR;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_remote_cmd_seq.sv
// Scoreboard bench for remote_cmd_seq: the driver plays host and transmitter stub,
// a negedge monitor checks every send/done/error event against queued expectations.
module tb_remote_cmd_seq;
    localparam int CMD_W  = 16;
    localparam int RESP_W = 8;
    localparam int DEPTH  = 8;
    localparam int TMO_W  = 24;
    localparam int EV_DONE = 0;
    localparam int EV_ERESP = 1;
    localparam int EV_ETMO = 2;

    typedef struct {
        int kind;
        int data;
    } evt_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n_send;
    int   n_done;
    bit   prev_err_resp;
    bit   prev_err_tmo;

    logic [CMD_W-1:0] send_q[$];
    evt_t             evt_q[$];

    remote_cmd_seq_if #(.CMD_W(CMD_W), .RESP_W(RESP_W), .TMO_W(TMO_W)) bus();

    remote_cmd_seq #(
        .CMD_W(CMD_W), .RESP_W(RESP_W), .DEPTH(DEPTH), .TMO_W(TMO_W), .EXP_RESP(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic report_unexpected(input string name, input logic [31:0] actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=%0h required=no_event", name, actual);
    endtask

    // Monitor: every output event must match the next queued expectation.
    always @(negedge clk) begin
        evt_t ev;
        if (!rst) begin
            if (bus.send_cmd) begin
                n_send++;
                if (send_q.size() == 0) report_unexpected("send_cmd", bus.cmd);
                else check_output("send_cmd_value", bus.cmd, send_q.pop_front());
            end
            if (bus.cmd_done) begin
                n_done++;
                if (evt_q.size() == 0) report_unexpected("cmd_done", bus.resp_cnt);
                else begin
                    ev = evt_q.pop_front();
                    check_output("done_kind", EV_DONE, ev.kind);
                    check_output("done_resp_cnt", bus.resp_cnt, ev.data);
                end
            end
            if (bus.err_resp && !prev_err_resp) begin
                if (evt_q.size() == 0) report_unexpected("err_resp", bus.bad_resp);
                else begin
                    ev = evt_q.pop_front();
                    check_output("err_resp_kind", EV_ERESP, ev.kind);
                    check_output("bad_resp_value", bus.bad_resp, ev.data);
                end
            end
            if (bus.err_tmo && !prev_err_tmo) begin
                if (evt_q.size() == 0) report_unexpected("err_tmo", bus.resp_cnt);
                else begin
                    ev = evt_q.pop_front();
                    check_output("err_tmo_kind", EV_ETMO, ev.kind);
                end
            end
        end
        prev_err_resp = bus.err_resp;
        prev_err_tmo  = bus.err_tmo;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_evt(input int kind, input int data);
        evt_t ev;
        ev.kind = kind;
        ev.data = data;
        evt_q.push_back(ev);
    endtask

    // Reference FIFO: an entry is kept only if fewer than DEPTH are waiting.
    task automatic apply_stimulus(input logic [CMD_W-1:0] c, input logic [7:0] n);
        bus.push       = 1'b1;
        bus.push_cmd   = c;
        bus.push_nresp = n;
        if (send_q.size() < DEPTH) send_q.push_back(c);
        tick();
        bus.push = 1'b0;
    endtask

    task automatic wait_send();
        int n = 0;
        while (bus.send_cmd !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        if (bus.send_cmd !== 1'b1) report_unexpected("send_wait_expired", n);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        if (bus.busy !== 1'b0) report_unexpected("idle_wait_expired", n);
        tick();
    endtask

    task automatic pulse_resp(input logic [7:0] b);
        bus.resp_rdy = 1'b1;
        bus.resp     = b;
        tick();
        bus.resp_rdy = 1'b0;
        bus.resp     = 8'($urandom);
    endtask

    // Transmitter stub: cmd_sent after dly cycles, then nresp bytes with random gaps.
    task automatic serve(input int nresp, input int dly, input int bad_idx,
                         input logic [7:0] bad_val);
        tick();
        repeat (dly) tick();
        if (nresp == 0) push_evt(EV_DONE, 0);
        bus.cmd_sent = 1'b1;
        tick();
        bus.cmd_sent = 1'b0;
        for (int i = 0; i < nresp; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            if (i == bad_idx) begin
                push_evt(EV_ERESP, bad_val);
                pulse_resp(bad_val);
                break;
            end
            if (i == nresp - 1) push_evt(EV_DONE, nresp);
            pulse_resp(8'hA5);
        end
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        send_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_send_cmd"}, bus.send_cmd, 0);
        check_output({tag, "_cmd"},      bus.cmd, 0);
        check_output({tag, "_busy"},     bus.busy, 0);
        check_output({tag, "_cmd_done"}, bus.cmd_done, 0);
        check_output({tag, "_resp_cnt"}, bus.resp_cnt, 0);
        check_output({tag, "_err_resp"}, bus.err_resp, 0);
        check_output({tag, "_err_tmo"},  bus.err_tmo, 0);
        check_output({tag, "_bad_resp"}, bus.bad_resp, 0);
        check_output({tag, "_full"},     bus.full, 0);
        check_output({tag, "_empty"},    bus.empty, 1);
    endtask

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog sim_time=%0t required=finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [CMD_W-1:0] qcmd[8];
        int               qn[8];
        int               base_send;
        int               base_done;
        int               nr;
        logic [CMD_W-1:0] c;

        checks = 0; errors = 0; n_send = 0; n_done = 0;
        rst = 1'b1;
        bus.push = 1'b0; bus.push_cmd = '0; bus.push_nresp = '0;
        bus.tmo_val = 24'd1000; bus.abort = 1'b0;
        bus.cmd_sent = 1'b0; bus.resp_rdy = 1'b0; bus.resp = '0;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Calibrate: pop the cycle after the push, send_cmd the cycle after that.
        base_send = n_send; base_done = n_done;
        apply_stimulus(16'h2000, 8'd1);
        check_output("cal_send_early", bus.send_cmd, 0);
        tick();
        check_output("cal_send_latency", bus.send_cmd, 1);
        check_output("cal_busy", bus.busy, 1);
        serve(1, 99, -1, 8'h00);
        wait_idle();
        check_output("cal_resp_cnt", bus.resp_cnt, 1);
        check_output("cal_err_resp", bus.err_resp, 0);
        check_output("cal_err_tmo", bus.err_tmo, 0);
        check_output("cal_cmd_stable", bus.cmd, 16'h2000);
        check_output("cal_send_pulses", n_send - base_send, 1);
        check_output("cal_done_pulses", n_done - base_done, 1);

        // Tour: 50 responses, one completion.
        base_done = n_done;
        apply_stimulus(16'h6022, 8'd50);
        wait_send();
        serve(50, $urandom_range(0, 10), -1, 8'h00);
        wait_idle();
        check_output("tour_resp_cnt", bus.resp_cnt, 50);
        check_output("tour_done_pulses", n_done - base_done, 1);

        // Queueing: a stalled blocker keeps the FIFO from draining while 9 pushes land.
        bus.tmo_val = '0;
        base_send = n_send; base_done = n_done;
        apply_stimulus(16'hB000, 8'd0);
        wait_send();
        for (int i = 0; i < 8; i++) begin
            qcmd[i] = 16'($urandom);
            qn[i]   = $urandom_range(0, 4);
            apply_stimulus(qcmd[i], 8'(qn[i]));
        end
        check_output("queue_full", bus.full, 1);
        apply_stimulus(16'hDEAD, 8'd1);
        check_output("queue_full_after_drop", bus.full, 1);
        serve(0, 3, -1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            wait_send();
            check_output("queue_cmd_order", bus.cmd, qcmd[i]);
            serve(qn[i], $urandom_range(0, 5), -1, 8'h00);
        end
        wait_idle();
        check_output("queue_sends", n_send - base_send, 9);
        check_output("queue_dones", n_done - base_done, 9);
        check_output("queue_empty", bus.empty, 1);

        // Bad response: second byte wrong, queued command must stay queued.
        bus.tmo_val = 24'd500;
        base_send = n_send;
        apply_stimulus(16'hA001, 8'd3);
        wait_send();
        apply_stimulus(16'hA002, 8'd1);
        serve(3, 2, 1, 8'h5A);
        wait_idle();
        repeat (20) tick();
        check_output("bad_err_resp", bus.err_resp, 1);
        check_output("bad_bad_resp", bus.bad_resp, 8'h5A);
        check_output("bad_err_tmo", bus.err_tmo, 0);
        check_output("bad_no_pop", bus.empty, 0);
        check_output("bad_sends", n_send - base_send, 1);
        check_output("bad_resp_cnt", bus.resp_cnt, 2);
        do_abort();
        check_output("abort_err_resp", bus.err_resp, 0);
        check_output("abort_bad_resp", bus.bad_resp, 0);
        check_output("abort_empty", bus.empty, 1);
        check_output("abort_busy", bus.busy, 0);
        repeat (5) tick();
        check_output("abort_no_send", n_send - base_send, 1);

        // Timeout: err_tmo exactly 1000 cycles after entering WAIT_SENT.
        bus.tmo_val = 24'd1000;
        apply_stimulus(16'hC001, 8'd2);
        wait_send();
        push_evt(EV_ETMO, 0);
        repeat (1000) tick();
        check_output("tmo_not_yet", bus.err_tmo, 0);
        tick();
        check_output("tmo_fired", bus.err_tmo, 1);
        check_output("tmo_busy", bus.busy, 0);
        do_abort();
        check_output("tmo_abort_clear", bus.err_tmo, 0);

        // A response in the expiry cycle wins over the timer.
        apply_stimulus(16'hC002, 8'd2);
        wait_send();
        repeat (5) tick();
        bus.cmd_sent = 1'b1;
        tick();
        bus.cmd_sent = 1'b0;
        repeat (999) tick();
        pulse_resp(8'hA5);
        check_output("expiry_resp_wins", bus.err_tmo, 0);
        check_output("expiry_resp_cnt", bus.resp_cnt, 1);
        check_output("expiry_busy", bus.busy, 1);
        push_evt(EV_DONE, 2);
        pulse_resp(8'hA5);
        wait_idle();
        check_output("expiry_err_tmo_after", bus.err_tmo, 0);

        // Reset in the middle of WAIT_RESP.
        bus.tmo_val = '0;
        apply_stimulus(16'hD001, 8'd5);
        wait_send();
        tick();
        bus.cmd_sent = 1'b1;
        tick();
        bus.cmd_sent = 1'b0;
        pulse_resp(8'hA5);
        pulse_resp(8'hA5);
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        tick();
        apply_stimulus(16'hD002, 8'd2);
        wait_send();
        serve(2, 1, -1, 8'h00);
        wait_idle();
        check_output("post_rst_resp_cnt", bus.resp_cnt, 2);

        // Random commands, with stray resp_rdy pulses after completion.
        for (int it = 0; it < 20; it++) begin
            bus.tmo_val = ($urandom_range(0, 1) != 0) ? 24'd0 : 24'd64;
            c  = 16'($urandom);
            nr = $urandom_range(0, 6);
            apply_stimulus(c, 8'(nr));
            wait_send();
            serve(nr, $urandom_range(0, 10), -1, 8'h00);
            wait_idle();
            check_output("rand_resp_cnt", bus.resp_cnt, nr);
            if ($urandom_range(0, 2) == 0) begin
                pulse_resp(8'h5A);
                tick();
            end
            check_output("rand_err_resp", bus.err_resp, 0);
        end

        repeat (5) tick();
        check_output("final_send_q", send_q.size(), 0);
        check_output("final_evt_q", evt_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
